// File: rtl/aq_djpeg_mcu_sched.sv
`default_nettype none
// ============================================================================
// Module   : aq_djpeg_mcu_sched
// Purpose  : JPEG decoder MCU block scheduler: block order, MCU position,
//            restart-interval requests and end-of-frame signalling.
// Revision : 1.0 - initial release
// ============================================================================
module aq_djpeg_mcu_sched #(
    parameter int MCU_W_BITS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ProcessInit,
    input  logic [2:0]            JpegComp,
    input  logic [1:0]            SubSamplingW,
    input  logic [1:0]            SubSamplingH,
    input  logic [MCU_W_BITS-1:0] McuCols,
    input  logic [MCU_W_BITS-1:0] McuRows,
    input  logic [15:0]           RestartInterval,
    input  logic                  BlockDone,
    output logic [2:0]            BlockColor,
    output logic [MCU_W_BITS-1:0] McuX,
    output logic [MCU_W_BITS-1:0] McuY,
    output logic                  RestartReq,
    output logic                  Busy,
    output logic                  FrameEnd,
    output logic                  SeqError
);

    localparam logic [MCU_W_BITS-1:0] c_one = MCU_W_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RESTART = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                r_state;
    logic [2:0]            r_yLast;
    logic                  r_hasChroma;
    logic [MCU_W_BITS-1:0] r_colLast;
    logic [MCU_W_BITS-1:0] r_rowLast;
    logic [15:0]           r_rstInt;
    logic [15:0]           r_rstCnt;

    logic                  w_twoW;
    logic                  w_twoH;
    logic [2:0]            w_yLastIn;
    logic [MCU_W_BITS-1:0] w_colLastIn;
    logic [MCU_W_BITS-1:0] w_rowLastIn;
    logic                  w_mcuLast;
    logic [2:0]            w_nextColor;
    logic                  w_lastX;
    logic                  w_lastY;
    logic [15:0]           w_rstCntNext;
    logic                  w_restart;

    // Configuration decode; stored as "last index" values so a zero size clamps to one.
    assign w_twoW      = (SubSamplingW == 2'd2);
    assign w_twoH      = (SubSamplingH == 2'd2);
    assign w_yLastIn   = (JpegComp == 3'd1)  ? 3'd0 :
                         (w_twoW && w_twoH)  ? 3'd3 :
                         (w_twoW || w_twoH)  ? 3'd1 : 3'd0;
    assign w_colLastIn = (McuCols == '0) ? '0 : McuCols - c_one;
    assign w_rowLastIn = (McuRows == '0) ? '0 : McuRows - c_one;

    assign w_mcuLast    = r_hasChroma ? (BlockColor == 3'd5) : (BlockColor == r_yLast);
    assign w_nextColor  = (BlockColor == r_yLast) ? 3'd4 : BlockColor + 3'd1;
    assign w_lastX      = (McuX == r_colLast);
    assign w_lastY      = (McuY == r_rowLast);
    assign w_rstCntNext = r_rstCnt + 16'd1;
    assign w_restart    = (r_rstInt != 16'd0) && (w_rstCntNext == r_rstInt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_yLast     <= 3'd0;
            r_hasChroma <= 1'b0;
            r_colLast   <= '0;
            r_rowLast   <= '0;
            r_rstInt    <= 16'd0;
            r_rstCnt    <= 16'd0;
            BlockColor  <= 3'd0;
            McuX        <= '0;
            McuY        <= '0;
            RestartReq  <= 1'b0;
            Busy        <= 1'b0;
            FrameEnd    <= 1'b0;
            SeqError    <= 1'b0;
        end else if (ProcessInit) begin
            r_state     <= S_RUN;
            r_yLast     <= w_yLastIn;
            r_hasChroma <= (JpegComp != 3'd1);
            r_colLast   <= w_colLastIn;
            r_rowLast   <= w_rowLastIn;
            r_rstInt    <= RestartInterval;
            r_rstCnt    <= 16'd0;
            BlockColor  <= 3'd0;
            McuX        <= '0;
            McuY        <= '0;
            RestartReq  <= 1'b0;
            Busy        <= 1'b1;
            FrameEnd    <= 1'b0;
            SeqError    <= 1'b0;
        end else begin
            RestartReq <= 1'b0;
            if (BlockDone && (r_state != S_RUN)) begin
                SeqError <= 1'b1;
            end
            case (r_state)
                S_RESTART: r_state <= S_RUN;
                S_RUN: begin
                    if (BlockDone) begin
                        if (!w_mcuLast) begin
                            BlockColor <= w_nextColor;
                        end else if (w_lastX && w_lastY) begin
                            // Final MCU: position and colour freeze, restart boundary is moot.
                            r_state  <= S_DONE;
                            Busy     <= 1'b0;
                            FrameEnd <= 1'b1;
                        end else begin
                            BlockColor <= 3'd0;
                            if (w_lastX) begin
                                McuX <= '0;
                                McuY <= McuY + c_one;
                            end else begin
                                McuX <= McuX + c_one;
                            end
                            if (w_restart) begin
                                r_rstCnt   <= 16'd0;
                                r_state    <= S_RESTART;
                                RestartReq <= 1'b1;
                            end else begin
                                r_rstCnt <= w_rstCntNext;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
